// File: rtl/j_jbus_seq.sv
// j_jbus_seq: load/store to external bus cycle sequencer; splits 32-bit accesses on a 16-bit bus (optional ack timeout: JBUS_TIMEOUT_EN).
// Latency: (ack wait + 1) + 1 clocks single, ack waits + 3 clocks split; done pulses one clock after the final ack.
// Backpressure: busy holds off the core (go ignored) until the access completes; ack stretches each bus cycle.
module j_jbus_seq #(
  parameter int TO_W   = 8,
  parameter int TO_MAX = 200
) (
  input  logic       clk,
  input  logic       resetl,
  input  logic       go,
  input  logic       rd,
  input  logic       long,
  input  logic       dsp16,
  input  logic       bigend,
  input  logic       ack,
  output logic       busreq,
  output logic       ainen,
  output logic       seta1,
  output logic       masterdata,
  output logic       dren,
  output logic [1:0] dinlatch,
  output logic [1:0] dmuxd,
  output logic [1:0] dmuxu,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, C1, C2, FIN} state_t;

  state_t state, state_nxt;
  logic   rd_q, long_q, two_q, hi1_q, first_q;
  logic   in_cyc, ack_v, take, enter, to_hit, half;

  if (TO_MAX < 1 || TO_MAX >= (1 << TO_W)) begin : g_to_max_check
    $error("j_jbus_seq: TO_MAX must be in 1 .. 2**TO_W-1");
  end

  assign in_cyc = (state == C1) || (state == C2);
  // The entry cycle of each bus cycle never counts an ack.
  assign ack_v  = in_cyc & ack & ~first_q;
  assign take   = (state == IDLE) & go;
  assign enter  = (state_nxt != state) && ((state_nxt == C1) || (state_nxt == C2));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = C1;
      C1: begin
        if (ack_v)       state_nxt = two_q ? C2 : FIN;
        else if (to_hit) state_nxt = FIN;
      end
      C2: if (ack_v || to_hit) state_nxt = FIN;
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      long_q  <= 1'b0;
      two_q   <= 1'b0;
      hi1_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      first_q <= enter;
      if (take) begin
        rd_q   <= rd;
        long_q <= long;
        two_q  <= dsp16 & long;
        hi1_q  <= bigend;
      end
    end
  end

  // Which 16-bit half of the word the current split cycle moves.
  assign half = (state == C1) ? hi1_q : ~hi1_q;

  always_comb begin
    busreq     = in_cyc;
    ainen      = in_cyc;
    seta1      = (state == C2);
    masterdata = in_cyc & ~rd_q;
    dren       = in_cyc & rd_q;
    dmuxd      = {1'b0, in_cyc & two_q & half};
    dmuxu      = 2'b00;
    busy       = in_cyc;
    done       = (state == FIN);
    dinlatch   = 2'b00;
    if (ack_v && rd_q) begin
      if (two_q)       dinlatch = half ? 2'b10 : 2'b01;
      else if (long_q) dinlatch = 2'b11;
      else             dinlatch = 2'b01;
    end
  end

`ifdef JBUS_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign to_hit = in_cyc & ~ack_v & (to_cnt == TO_W'(TO_MAX - 1));

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (enter)
        to_cnt <= '0;
      else if (in_cyc && !ack_v && to_cnt != {TO_W{1'b1}})
        to_cnt <= to_cnt + 1'b1;
      if (take)
        err <= 1'b0;
      else if (to_hit)
        err <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_j_jbus_seq.sv
// Randomized scoreboard bench for j_jbus_seq: driver pushes expected bus-cycle and completion records, monitor pops on counted acks and done.
module tb_j_jbus_seq;

  localparam int TO_MAX = 200;

  logic       clk = 1'b0;
  logic       resetl, go, rd, long, dsp16, bigend, ack;
  logic       busreq, ainen, seta1, masterdata, dren, busy, done, err;
  logic [1:0] dinlatch, dmuxd, dmuxu;

  j_jbus_seq #(.TO_W(8), .TO_MAX(TO_MAX)) dut (
    .clk(clk), .resetl(resetl), .go(go), .rd(rd), .long(long),
    .dsp16(dsp16), .bigend(bigend), .ack(ack),
    .busreq(busreq), .ainen(ainen), .seta1(seta1), .masterdata(masterdata),
    .dren(dren), .dinlatch(dinlatch), .dmuxd(dmuxd), .dmuxu(dmuxu),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int go_cyc;
    int lat;
    int ncyc;
    bit err;
  } done_t;

  logic [11:0] ph_q[$];
  done_t       done_q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          counted = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: each bus cycle moves one half h of the word (split) or the whole access.
  task automatic push_phases(input bit r, input bit l, input bit d16, input bit be, input int nph);
    bit two;
    bit h;
    logic [1:0] dl, dm;
    two = d16 & l;
    for (int p = 1; p <= nph; p++) begin
      h  = two ? ((p == 1) ? be : !be) : 1'b0;
      dm = two ? {1'b0, h} : 2'b00;
      if (!r)       dl = 2'b00;
      else if (two) dl = 2'(1 << h);
      else          dl = l ? 2'b11 : 2'b01;
      // {busy, busreq, ainen, seta1, masterdata, dren, dmuxd, dmuxu, dinlatch}
      ph_q.push_back({1'b1, 1'b1, 1'b1, (p == 2), !r, r, dm, 2'b00, dl});
    end
  endtask

  task automatic noise();
    go     = ($urandom_range(0, 3) == 0);
    rd     = 1'($urandom);
    long   = 1'($urandom);
    dsp16  = 1'($urandom);
    bigend = 1'($urandom);
  endtask

  // Entry cycle may carry a spurious ack; the counted ack comes w cycles later.
  task automatic run_phase(input int w);
    ack = 1'($urandom); counted = 1'b0; noise(); step();
    repeat (w - 1) begin ack = 1'b0; noise(); step(); end
    ack = 1'b1; counted = 1'b1; noise(); step();
    ack = 1'b0; counted = 1'b0;
  endtask

  task automatic txn(input bit r, input bit l, input bit d16, input bit be, input int w1, input int w2);
    done_t e;
    bit two;
    two = d16 & l;
    push_phases(r, l, d16, be, two ? 2 : 1);
    e.go_cyc = cyc;
    e.lat    = two ? (w1 + w2 + 3) : (w1 + 2);
    e.ncyc   = (w1 + 1) + (two ? (w2 + 1) : 0);
    e.err    = 1'b0;
    done_q.push_back(e);
    go = 1'b1; rd = r; long = l; dsp16 = d16; bigend = be; ack = 1'b0;
    step();
    go = 1'b0;
    run_phase(w1);
    if (two) run_phase(w2);
    go = 1'b0;
    step();
    repeat ($urandom_range(0, 2)) step();
  endtask

  int ncyc = 0;

  initial forever begin
    @(negedge clk);
    if (!resetl) begin
      ncyc = 0;
    end else begin
      if (busreq) ncyc++;
      if (counted) begin
        if (ph_q.size() == 0) chk("ph_unexpected", 1, 0);
        else chk("ph_outputs",
                 {busy, busreq, ainen, seta1, masterdata, dren, dmuxd, dmuxu, dinlatch},
                 ph_q.pop_front());
      end else if (dinlatch != 2'b00) begin
        chk("dinlatch_stray", dinlatch, 0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_latency", cyc - e.go_cyc, e.lat);
          chk("done_bus_cycles", ncyc, e.ncyc);
          chk("done_err", err, e.err);
          chk("done_busy_busreq", {busy, busreq}, 0);
        end
        ncyc = 0;
      end
    end
  end

  initial begin
    resetl = 1'b0; go = 1'b0; rd = 1'b0; long = 1'b0;
    dsp16 = 1'b0; bigend = 1'b0; ack = 1'b0;
    #2;
    chk("reset_outputs",
        {busreq, ainen, seta1, masterdata, dren, dinlatch, dmuxd, dmuxu, busy, done, err}, 0);
    repeat (2) step();
    resetl = 1'b1;
    step();

    txn(1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
    txn(1'b0, 1'b1, 1'b1, 1'b0, 2, 4);
    txn(1'b1, 1'b1, 1'b1, 1'b1, 2, 3);
    txn(1'b1, 1'b0, 1'b1, 1'b1, 1, 0);
    txn(1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

    for (int i = 0; i < 40; i++)
      txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(1, 5), $urandom_range(1, 5));

    // Abort a split read in its second cycle: only the first cycle's response is expected.
    push_phases(1'b1, 1'b1, 1'b1, 1'b0, 1);
    go = 1'b1; rd = 1'b1; long = 1'b1; dsp16 = 1'b1; bigend = 1'b0; ack = 1'b0;
    step();
    go = 1'b0;
    run_phase(2);
    ack = 1'b0;
    step();
    chk("pre_abort_in_c2", {busy, seta1}, 2'b11);
    resetl = 1'b0;
    #1;
    chk("abort_outputs",
        {busreq, ainen, seta1, masterdata, dren, dinlatch, dmuxd, dmuxu, busy, done, err}, 0);
    repeat (3) step();
    resetl = 1'b1;
    step();
    txn(1'b1, 1'b1, 1'b1, 1'b1, 2, 2);

`ifdef JBUS_TIMEOUT_EN
    begin
      done_t e;
      e.go_cyc = cyc;
      e.lat    = TO_MAX + 1;
      e.ncyc   = TO_MAX;
      e.err    = 1'b1;
      done_q.push_back(e);
      go = 1'b1; rd = 1'b1; long = 1'b1; dsp16 = 1'b0; ack = 1'b0;
      step();
      go = 1'b0;
      repeat (TO_MAX + 5) step();
      chk("err_sticky", err, 1);
      txn(1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
      chk("err_cleared", err, 0);
    end
`endif

    repeat (4) step();
    chk("scoreboard_drained", ph_q.size() + done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/j_jbus_seq.md
Name: j_jbus_seq

Overview:
- Bus-cycle sequencer directly upstream of the DSP external bus interface (j_jbus).
- Converts single-cycle load/store requests from the DSP core into external bus transactions on a 32-bit or 16-bit bus.
- Drives j_jbus's steering and latch controls (dinlatch, dmuxd, dmuxu, dren, ainen, seta1, masterdata) and consumes its dsp16/bigend configuration outputs.
- On a 16-bit bus, splits each 32-bit access into two half-word cycles and holds the core until the full access completes.

Parameters:
- TO_W, 8, width of the ack-timeout counter (used only with JBUS_TIMEOUT_EN).
- TO_MAX, 200, cycles without ack before a timeout abort (must be < 2^TO_W).

Ports:
- clk  in  1  system clock; all state on rising edge
- resetl  in  1  asynchronous active-low reset
- go  in  1  core request strobe, one cycle; sampled only when busy=0
- rd  in  1  1 = read, 0 = write; sampled with go
- long  in  1  1 = 32-bit access, 0 = 16-bit access; sampled with go
- dsp16  in  1  from j_jbus: 1 = external bus is 16 bits wide
- bigend  in  1  from j_jbus: big-endian half ordering
- ack  in  1  external bus acknowledge for the current cycle
- busreq  out  1  external bus cycle request
- ainen  out  1  drive address onto the external bus
- seta1  out  1  force address bit 1 high (second half-word cycle)
- masterdata  out  1  DSP drives the data bus (write cycle)
- dren  out  1  enable read data onto the internal bus
- dinlatch  out  2  [0] latches the low 16 of dr, [1] latches the high 16
- dmuxd  out  2  low-lane write data select: 00 = wd[15:0], 01 = wd[31:16]
- dmuxu  out  2  high-lane write data select: 00 = wd[31:16], 01 = wd[15:0]
- busy  out  1  access in progress
- done  out  1  one-cycle pulse when the access completes
- err  out  1  sticky timeout flag; cleared by the next accepted go

Behaviour:
- Reset: all outputs 0, dmuxd/dmuxu 00, state IDLE. Reset asserted mid-access aborts immediately with no done pulse.
- Split decision, latched at go: two = dsp16 & long. Also latched at go: rd, long, and first-half selection hi1 = bigend.
- States:
  - IDLE: go → C1, busy=1.
  - C1: busreq=1, ainen=1, seta1=0, masterdata=~rd.
    - ack & two → C2.
    - ack & ~two → FIN.
  - C2: busreq=1, ainen=1, seta1=1, masterdata=~rd.
    - ack → FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- go is ignored while busy=1.
- An ack arriving in the same cycle as entry into C1 or C2 is not counted. ack is sampled only from the cycle after entry onward, so a cycle lasts at least 2 clocks.
- Write lane steering (held for the whole cycle):
  - Non-split: dmuxd=00, dmuxu=00.
  - Split, C1: dmuxd=01 if hi1 else 00.
  - Split, C2: dmuxd=00 if hi1 else 01.
  - dmuxu is 00 in all cases.
- Read latching: dren=1 throughout C1/C2 when rd=1. dinlatch is a one-cycle pulse on the ack cycle:
  - Non-split 32-bit: 11.
  - Non-split 16-bit: 01.
  - Split, C1: 10 if hi1 else 01.
  - Split, C2: 01 if hi1 else 10.
- Writes: dinlatch stays 00.
- done asserts exactly 1 cycle after the final ack cycle.
- Latency: single cycle = (ack wait + 1) + 1 clocks; split = sum of both ack waits + 3 clocks.

Optional Feature:
- Macro: JBUS_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entry to C1/C2 and increments each cycle without ack.
  - Reaching TO_MAX → FIN with err=1, done pulses, and all bus outputs drop the same cycle.
  - The counter saturates; it never wraps.
- Undefined: no counter; err is tied 0; the sequencer waits on ack indefinitely.

Test Plan:
- dsp16=0, go rd=1 long=1, ack after 3 clocks → one busreq cycle, seta1 never set, dinlatch=11 on the ack cycle, done 1 clock later, busy then 0.
- dsp16=1, bigend=0, go rd=0 long=1, ack at 2 then 4 clocks → C1 dmuxd=00 seta1=0, C2 dmuxd=01 seta1=1, masterdata=1 throughout, single done pulse.
- dsp16=1, bigend=1, read long → dinlatch 10 in C1, 01 in C2; dren=1 over both cycles.
- go pulsed in C1 and again in C2 → ignored; exactly one done pulse; the following go is accepted normally.
- resetl low during C2 → all outputs 0 asynchronously, no done pulse; after release, IDLE accepts a new go.
- JBUS_TIMEOUT_EN with TO_MAX=200, ack never asserted → done and err at cycle 200; the next go clears err.
